// File: rtl/uart_packet_sequencer.sv
// Frames the UART byte stream into SYNC/CMD/DATA/CHK packets and drives two
// persistent joypad registers; malformed or stalled packets are counted.
module uart_packet_sequencer #(
   parameter int unsigned CLK_FREQ_HZ = 115200000,
   parameter int unsigned TIMEOUT_US  = 1000,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       buffer_ready_o,
   input  logic       hold_i,
   output logic [7:0] joypad1_o,
   output logic [7:0] joypad2_o,
   output logic       update_o,
   output logic       error_o,
   output logic [7:0] error_count_o
);

   localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000000) * TIMEOUT_US;
   localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] CMD_JOY1 = 8'h01;
   localparam logic [7:0] CMD_JOY2 = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_CMD,
      S_GET_DATA,
      S_GET_CHK,
      S_COMMIT
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_timer;
   logic [7:0]       r_cmd;
   logic [7:0]       r_data;
   logic             r_ok;
   logic [7:0]       r_joy1;
   logic [7:0]       r_joy2;
   logic             r_update;
   logic             r_error;
   logic [7:0]       r_err_cnt;

   logic w_ready;
   logic w_accept;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_ready  = !hold_i && (r_state != S_COMMIT);
   assign w_accept = data_valid_i && w_ready;

   // Packet payload is only consumed in COMMIT, after it has been written.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         case (r_state)
            S_GET_CMD:  r_cmd  <= data_i;
            S_GET_DATA: r_data <= data_i;
            S_GET_CHK:  r_ok   <= (data_i == (SYNC_BYTE ^ r_cmd ^ r_data)) &&
                                  ((r_cmd == CMD_JOY1) || (r_cmd == CMD_JOY2));
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_joy1    <= 8'h00;
         r_joy2    <= 8'h00;
         r_update  <= 1'b0;
         r_error   <= 1'b0;
         r_err_cnt <= 8'h00;
      end else begin
         r_update <= 1'b0;
         r_error  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_timer <= '0;
               if (w_accept && (data_i == SYNC_BYTE)) r_state <= S_GET_CMD;
            end
            S_GET_CMD, S_GET_DATA, S_GET_CHK: begin
               // An acceptance in the expiry cycle takes priority over the timeout.
               if (w_accept) begin
                  r_timer <= '0;
                  case (r_state)
                     S_GET_CMD:  r_state <= S_GET_DATA;
                     S_GET_DATA: r_state <= S_GET_CHK;
                     default:    r_state <= S_COMMIT;
                  endcase
               end else if (r_timer == TIMER_LAST) begin
                  r_timer   <= '0;
                  r_state   <= S_IDLE;
                  r_error   <= 1'b1;
                  r_err_cnt <= sat_inc(r_err_cnt);
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_COMMIT: begin
               r_timer <= '0;
               r_state <= S_IDLE;
               if (r_ok) begin
                  if (r_cmd == CMD_JOY1) r_joy1 <= r_data;
                  else                   r_joy2 <= r_data;
                  r_update <= 1'b1;
               end else begin
                  r_error   <= 1'b1;
                  r_err_cnt <= sat_inc(r_err_cnt);
               end
            end
            default: begin
               r_timer <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign buffer_ready_o = w_ready;
   assign joypad1_o      = r_joy1;
   assign joypad2_o      = r_joy2;
   assign update_o       = r_update;
   assign error_o        = r_error;
   assign error_count_o  = r_err_cnt;

endmodule
